spi_switch_arbiter: RTL and testbench
=====================================

SPI_SWITCH_ARBITER -- requirements
Module: spi_switch_arbiter

Interface
REQ-001 Parameter PORTS, default 3, number of SPI masters sharing the bus; legal values 2 and 3 only.
REQ-002 Parameter GUARD_CYCLES, default 4, idle cycles inserted between release and next grant; 0..255.
REQ-003 Parameter MAX_HOLD, default 0, cycles an owner may hold the bus before preemption; 0 disables; 1..65535 otherwise.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_L  input  1  asynchronous, active-low reset.
REQ-006 req  input  PORTS  level request per master; held high for the whole ownership.
REQ-007 ss_L_ports  input  PORTS  per-master chip-select (active low), monitored to detect transactions in flight.
REQ-008 grant  output  PORTS  registered one-hot ownership flag per master.
REQ-009 select  output  PORTS  registered; drives the wire crossbar select; always equal to grant.
REQ-010 busy  output  1  registered; high in GRANT and GUARD states.
REQ-011 preempt  output  1  registered one-cycle pulse when MAX_HOLD forces a release.

Function
REQ-012 FSM states: IDLE, GRANT, GUARD; encoding free.
REQ-013 IDLE: if any req bit high, choose winner by round-robin, enter GRANT, assert grant/select for winner on the next edge (1-cycle latency from sampled req).
REQ-014 Round-robin: search starts at (last_owner+1) mod PORTS, increasing, wrapping; first set req bit wins; last_owner updated on every grant.
REQ-015 IDLE with req all zero: stay IDLE, grant=0, select=0.
REQ-016 GRANT: grant held constant while req[owner]=1, regardless of other requests.
REQ-017 GRANT, req[owner]=0 and ss_L_ports[owner]=1: next edge clears grant/select and enters GUARD.
REQ-018 GRANT, req[owner]=0 but ss_L_ports[owner]=0: grant held until ss_L_ports[owner]=1; transaction never cut mid-frame.
REQ-019 Hold counter: 16-bit, cleared on entry to GRANT, increments each GRANT cycle, saturates at 65535.
REQ-020 MAX_HOLD!=0, hold count >= MAX_HOLD, another req bit high, ss_L_ports[owner]=1: release as REQ-017 and pulse preempt for exactly one cycle coincident with grant falling.
REQ-021 Preemption blocked while ss_L_ports[owner]=0; evaluated each cycle until owner's ss_L rises.
REQ-022 GUARD: counter loaded with GUARD_CYCLES on entry, decrements each cycle; exits to IDLE when counter reaches 0; grant=0 throughout.
REQ-023 GUARD_CYCLES=0: release goes directly to IDLE (grant low one cycle, arbitration next cycle).
REQ-024 Grant never moves directly between masters; at least one all-zero grant cycle between owners.
REQ-025 Requests arriving or dropping during GUARD are ignored until IDLE samples them.
REQ-026 Preempted master keeping req high re-competes normally; round-robin places it last.
REQ-027 ss_L_ports of non-owners ignored.

Reset
REQ-028 rst_L low asynchronously forces state IDLE, grant=0, select=0, busy=0, preempt=0, counters 0, last_owner=PORTS-1 (port 0 highest priority after reset).
REQ-029 Reset asserted mid-GRANT drops grant immediately, without waiting for ss_L; first arbitration occurs on first edge after rst_L rises with req sampled then.

Verification
REQ-030 Reset, then req=3'b111 -> grant=3'b001 one cycle later; each owner drops req after release -> grant order 001,010,100 with >= GUARD_CYCLES+1 zero cycles between.
REQ-031 Owner 1 drops req while ss_L_ports[1]=0 for 10 cycles -> grant=3'b010 held those 10 cycles, clears one edge after ss_L_ports[1]=1.
REQ-032 MAX_HOLD=8, port 0 holds req, port 2 requests, ss_L_ports[0]=1 -> at hold count 8 grant falls, preempt pulses 1 cycle, after guard grant=3'b100.
REQ-033 Same as REQ-032 with ss_L_ports[0]=0 -> no preempt until ss_L_ports[0] rises; then release next edge.
REQ-034 GUARD_CYCLES=0, PORTS=2, req=2'b11 held, owners drop req alternately -> grants alternate 01,10 with exactly one zero cycle between.
REQ-035 rst_L pulsed low mid-GRANT -> grant/select/busy 0 immediately; after release, req=3'b100 -> grant=3'b100 one cycle later.

Source files
------------

// File: rtl/spi_switch_arbiter.sv
// spi_switch_arbiter: round-robin owner arbitration for SPI masters sharing one bus,
// with frame-safe release, a post-release guard gap and optional hold-time preemption.
module spi_switch_arbiter #(
    parameter int unsigned PORTS        = 3,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned MAX_HOLD     = 0
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic [PORTS-1:0] req,
    input  logic [PORTS-1:0] ss_L_ports,
    output logic [PORTS-1:0] grant,
    output logic [PORTS-1:0] select,
    output logic             busy,
    output logic             preempt
);
    localparam int unsigned OW = $clog2(PORTS);
    localparam logic [PORTS-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [15:0]     hold_cnt;
    logic [7:0]      guard_cnt;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   rr_idx;
    logic            win_found;
    logic [15:0]     hold_inc;
    logic            own_req;
    logic            own_ss_idle;
    logic            others;
    logic            rel_pre;
    logic            rel;

    // Search starts just after the previous owner so it naturally lands last.
    always_comb begin
        win_idx   = owner;
        win_found = 1'b0;
        rr_idx    = owner;
        for (int i = 1; i <= int'(PORTS); i++) begin
            rr_idx = OW'((int'(owner) + i) % int'(PORTS));
            if (!win_found && req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    assign own_req     = req[owner];
    assign own_ss_idle = ss_L_ports[owner];
    assign others      = |(req & ~grant);
    assign hold_inc    = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
    // hold_inc counts the current cycle, so an owner keeps the bus exactly MAX_HOLD cycles.
    assign rel_pre     = (MAX_HOLD != 0) && own_req && others && (hold_inc >= 16'(MAX_HOLD));
    assign rel         = (!own_req || rel_pre) && own_ss_idle;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            grant     <= '0;
            select    <= '0;
            busy      <= 1'b0;
            preempt   <= 1'b0;
            owner     <= OW'(PORTS - 1);
            hold_cnt  <= '0;
            guard_cnt <= '0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= GRANT;
                        grant    <= ONE << win_idx;
                        select   <= ONE << win_idx;
                        owner    <= win_idx;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_inc;
                    if (rel) begin
                        grant     <= '0;
                        select    <= '0;
                        preempt   <= rel_pre;
                        guard_cnt <= 8'(GUARD_CYCLES);
                        state     <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
                        busy      <= (GUARD_CYCLES != 0);
                    end
                end
                GUARD: begin
                    guard_cnt <= guard_cnt - 8'd1;
                    if (guard_cnt <= 8'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_switch_arbiter.sv
// tb_spi_switch_arbiter: scoreboard bench for a 3-port guarded/preempting arbiter and a 2-port zero-guard one.
module tb_spi_switch_arbiter;
    localparam int GA = 4;

    logic       clk;
    logic       rst_L;
    logic [2:0] req_a, ss_a, grant_a, select_a;
    logic       busy_a, preempt_a;
    logic [1:0] req_b, ss_b, grant_b, select_b;
    logic       busy_b, preempt_b;

    int n_chk = 0;
    int n_pass = 0;
    int n, held, seen_pre;
    int pre_a = 0;
    int pre_b = 0;
    logic [2:0] exp_a[$];
    logic [1:0] exp_b[$];
    logic [2:0] prev_a, e_a;
    logic [1:0] prev_b, e_b, ev;
    bit seen_a, seen_b;
    int gap_a, gap_b;

    spi_switch_arbiter #(.PORTS(3), .GUARD_CYCLES(GA), .MAX_HOLD(8)) u_a (
        .clk(clk), .rst_L(rst_L), .req(req_a), .ss_L_ports(ss_a),
        .grant(grant_a), .select(select_a), .busy(busy_a), .preempt(preempt_a)
    );

    spi_switch_arbiter #(.PORTS(2), .GUARD_CYCLES(0), .MAX_HOLD(0)) u_b (
        .clk(clk), .rst_L(rst_L), .req(req_b), .ss_L_ports(ss_b),
        .grant(grant_b), .select(select_b), .busy(busy_b), .preempt(preempt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        else n_pass++;
    endtask

    task automatic wait_a(input logic [2:0] v, output int cnt);
        cnt = 0;
        while (grant_a !== v && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (grant_a !== v) cnt = -1;
    endtask

    task automatic wait_b(input logic [1:0] v, output int cnt);
        cnt = 0;
        while (grant_b !== v && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (grant_b !== v) cnt = -1;
    endtask

    task automatic wait_idle_a();
        int cnt = 0;
        while (busy_a !== 1'b0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("idle_busy", busy_a, 0);
        chk("idle_grant", grant_a, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_L) begin
            prev_a = 0; seen_a = 0; gap_a = 0;
            prev_b = 0; seen_b = 0; gap_b = 0;
        end else begin
            if (grant_a != 0 && prev_a == 0) begin
                if (exp_a.size() == 0) chk("a_unexpected", grant_a, 0);
                else begin
                    e_a = exp_a.pop_front();
                    chk("a_grant", grant_a, e_a);
                    chk("a_select", select_a, e_a);
                    if (seen_a) chk("a_gap", gap_a >= GA + 1, 1);
                end
                seen_a = 1; gap_a = 0;
            end else if (grant_a != 0 && grant_a != prev_a) chk("a_direct", grant_a, prev_a);
            else if (grant_a == 0) gap_a++;
            prev_a = grant_a;
            if (grant_b != 0 && prev_b == 0) begin
                if (exp_b.size() == 0) chk("b_unexpected", grant_b, 0);
                else begin
                    e_b = exp_b.pop_front();
                    chk("b_grant", grant_b, e_b);
                    chk("b_select", select_b, e_b);
                    if (seen_b) chk("b_gap", gap_b, 1);
                end
                seen_b = 1; gap_b = 0;
            end else if (grant_b != 0 && grant_b != prev_b) chk("b_direct", grant_b, prev_b);
            else if (grant_b == 0) gap_b++;
            prev_b = grant_b;
        end
        if (preempt_a === 1'b1) pre_a++;
        if (preempt_b === 1'b1) pre_b++;
    end

    initial begin
        clk = 0; rst_L = 1; req_a = 0; ss_a = '1; req_b = 0; ss_b = '1;
        #1 rst_L = 0;
        @(negedge clk);
        chk("rst_grant", grant_a, 0);
        chk("rst_select", select_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_preempt", preempt_a, 0);
        chk("rst_grant_b", grant_b, 0);
        #2 rst_L = 1;
        @(negedge clk);
        // round-robin sweep from reset
        req_a = 3'b111;
        exp_a.push_back(3'b001); exp_a.push_back(3'b010); exp_a.push_back(3'b100);
        @(negedge clk);
        chk("rr_first", grant_a, 3'b001);
        chk("rr_busy", busy_a, 1);
        req_a = 3'b110;
        wait_a(3'b010, n); chk("rr_gap1", n, 6);
        req_a = 3'b100;
        wait_a(3'b100, n); chk("rr_gap2", n, 6);
        req_a = 3'b000;
        @(negedge clk);
        chk("guard_grant", grant_a, 0);
        chk("guard_busy", busy_a, 1);
        wait_idle_a();
        // owner 1 drops req mid-frame; non-owner ss_L noise must not matter
        req_a = 3'b010; exp_a.push_back(3'b010);
        @(negedge clk);
        chk("ss_grant", grant_a, 3'b010);
        req_a = 3'b000; ss_a = 3'b100;
        held = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant_a == 3'b010) held++;
        end
        chk("ss_hold", held, 10);
        ss_a = 3'b110;
        @(negedge clk);
        chk("ss_release", grant_a, 0);
        ss_a = '1;
        wait_idle_a();
        // preemption after 8 cycles with owner idle on ss_L
        req_a = 3'b001; exp_a.push_back(3'b001);
        @(negedge clk);
        chk("pre_own", grant_a, 3'b001);
        req_a = 3'b101; exp_a.push_back(3'b100);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_a == 3'b001 && n < 50);
        chk("pre_hold", n, 8);
        chk("pre_fall", grant_a, 0);
        chk("pre_pulse", preempt_a, 1);
        @(negedge clk);
        chk("pre_width", preempt_a, 0);
        wait_a(3'b100, n); chk("pre_gap", n, 4);
        req_a = 3'b001; exp_a.push_back(3'b001);
        wait_a(3'b001, n); chk("pre_back", n, 6);
        // preemption blocked while owner's frame is in flight
        ss_a = 3'b110; req_a = 3'b101; exp_a.push_back(3'b100);
        held = 0; seen_pre = 0;
        repeat (15) begin
            @(negedge clk);
            if (grant_a == 3'b001) held++;
            if (preempt_a) seen_pre++;
        end
        chk("blk_hold", held, 15);
        chk("blk_nopre", seen_pre, 0);
        ss_a = '1;
        @(negedge clk);
        chk("blk_fall", grant_a, 0);
        chk("blk_pulse", preempt_a, 1);
        wait_a(3'b100, n); chk("blk_gap", n, 5);
        req_a = 3'b000;
        wait_idle_a();
        // reset mid-grant with a frame in flight
        req_a = 3'b010; exp_a.push_back(3'b010);
        @(negedge clk);
        chk("rmid_own", grant_a, 3'b010);
        ss_a = 3'b101;
        #2 rst_L = 0;
        #1;
        chk("rmid_grant", grant_a, 0);
        chk("rmid_select", select_a, 0);
        chk("rmid_busy", busy_a, 0);
        @(negedge clk);
        #2 rst_L = 1; req_a = 3'b100; ss_a = '1; exp_a.push_back(3'b100);
        @(negedge clk);
        chk("rmid_rearb", grant_a, 3'b100);
        req_a = 3'b000;
        wait_idle_a();
        // zero-guard two-port alternation
        exp_b.push_back(2'b01); exp_b.push_back(2'b10);
        exp_b.push_back(2'b01); exp_b.push_back(2'b10);
        req_b = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ev = k[0] ? 2'b10 : 2'b01;
            wait_b(ev, n); chk("alt_lat", n, 1);
            req_b = ev ^ 2'b11;
            @(negedge clk);
            chk("alt_zero", grant_b, 0);
            req_b = (k == 3) ? 2'b00 : 2'b11;
        end
        repeat (3) @(negedge clk);
        chk("a_sb_empty", exp_a.size(), 0);
        chk("b_sb_empty", exp_b.size(), 0);
        chk("a_preempts", pre_a, 2);
        chk("b_preempts", pre_b, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
